// File: rtl/alu_exec_unit_pkg.sv
// alu_exec_unit_pkg: shared op codes, decoded op and multiplier FSM state types.
package alu_exec_unit_pkg;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_MUL = 4'b0100;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_ILL = 2'b11} op_e;
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_MUL = 2'b01, S_FIN = 2'b10} state_e;
    function automatic op_e decode(input logic [3:0] code);
        return code == ALU_ADD ? OP_ADD : code == ALU_SUB ? OP_SUB : code == ALU_MUL ? OP_MUL : OP_ILL;
    endfunction
endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: start/busy/done request bus between operand read stage and the exec unit.
interface alu_exec_unit_if #(parameter int WIDTH = 32);
    logic start;
    logic [3:0] alu_control;
    logic [WIDTH-1:0] a, b;
    logic busy, done;
    logic [WIDTH-1:0] result, result_hi;
    logic zero, illegal;
    modport master(output start, alu_control, a, b, input busy, done, result, result_hi, zero, illegal);
    modport slave(input start, alu_control, a, b, output busy, done, result, result_hi, zero, illegal);
endinterface

// File: rtl/alu_exec_unit_seq_multiplier.sv
// seq_multiplier: unsigned shift-add multiplier, one step per cycle over WIDTH cycles.
// done flags the edge on which the final step lands; product is that final value.
module seq_multiplier
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    state_e state, state_nx;
    logic [WIDTH-1:0] mcand, acc_hi, acc_lo;
    logic [CW-1:0] count;
    logic [WIDTH:0] step;
    // carry lands in step[WIDTH] and is shifted straight into acc_hi's top bit
    assign step = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    assign busy = state == S_MUL;
    assign done = busy && count == CW'(WIDTH - 1);
    assign product = {step, acc_lo[WIDTH-1:1]};
    always_comb begin
        state_nx = state == S_MUL ? (done ? S_FIN : S_MUL) : (start ? S_MUL : S_IDLE);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            count <= '0;
            mcand <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
        end else begin
            state <= state_nx;
            if (busy) begin
                acc_hi <= step[WIDTH:1];
                acc_lo <= {step[0], acc_lo[WIDTH-1:1]};
                count <= count + 1'b1;
            end else if (start) begin
                mcand <= a;
                acc_hi <= '0;
                acc_lo <= b;
                count <= '0;
            end
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: decodes alu_control, does single-cycle add/sub and iterative multiply,
// and owns the registered result fields and flags.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          rst_n,
    alu_exec_unit_if.slave bus
);
    op_e op;
    logic accept, mul_busy, mul_done;
    logic [WIDTH-1:0] sum;
    logic [2*WIDTH-1:0] product;
    assign op = decode(bus.alu_control);
    assign accept = bus.start && !mul_busy;
    assign sum = op == OP_SUB ? bus.a - bus.b : bus.a + bus.b;
    assign bus.busy = mul_busy;
    seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk(clk),
        .rst_n(rst_n),
        .start(accept && op == OP_MUL),
        .a(bus.a),
        .b(bus.b),
        .busy(mul_busy),
        .done(mul_done),
        .product(product)
    );
    // a multiply finishing and a new accept are exclusive: accept needs !mul_busy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.done <= 1'b0;
            bus.result <= '0;
            bus.result_hi <= '0;
            bus.zero <= 1'b0;
            bus.illegal <= 1'b0;
        end else begin
            bus.done <= mul_done || (accept && op != OP_MUL);
            if (mul_done) begin
                bus.result <= product[WIDTH-1:0];
                bus.result_hi <= product[2*WIDTH-1:WIDTH];
                bus.zero <= product == '0;
                bus.illegal <= 1'b0;
            end else if (accept && op != OP_MUL) begin
                bus.result <= op == OP_ILL ? '0 : sum;
                bus.result_hi <= '0;
                bus.zero <= op != OP_ILL && sum == '0;
                bus.illegal <= op == OP_ILL;
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: randomized and directed checks of alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;
    localparam int W = 32;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    alu_exec_unit_if #(.WIDTH(W)) bus();
    alu_exec_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // {result_hi, result, zero, illegal}
    function automatic logic [2*W+1:0] model(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] s;
        logic [2*W-1:0] p;
        logic ill;
        ill = 1'b0;
        if (ctl == 4'b0010) begin
            s = a + b;
            p = {{W{1'b0}}, s};
        end else if (ctl == 4'b0011) begin
            s = a - b;
            p = {{W{1'b0}}, s};
        end else if (ctl == 4'b0100) begin
            p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        end else begin
            p = '0;
            ill = 1'b1;
        end
        return {p, !ill && p == '0, ill};
    endfunction

    function automatic int latency(input logic [3:0] ctl);
        return ctl == 4'b0100 ? W + 1 : 1;
    endfunction

    function automatic logic [3:0] rand_illegal();
        int c;
        c = $urandom_range(0, 12);
        return 4'(c < 2 ? c : c + 3);
    endfunction

    function automatic logic [3:0] rand_ctl();
        int r;
        r = $urandom_range(0, 3);
        return r == 0 ? 4'b0010 : r == 1 ? 4'b0011 : r == 2 ? 4'b0100 : rand_illegal();
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.alu_control = ctl;
        bus.a = a;
        bus.b = b;
    endtask

    task automatic release_bus();
        bus.start = 1'b0;
        bus.alu_control = 4'($urandom);
        bus.a = $urandom;
        bus.b = $urandom;
    endtask

    task automatic run_op(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        drive(ctl, a, b);
        tick();
        release_bus();
        lat = 1;
        while (!bus.done && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        release_bus();
        repeat (3) tick();
        checks++;
        if ({bus.busy, bus.done, bus.zero, bus.illegal, bus.result, bus.result_hi} !== '0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b zero=%b illegal=%b result=%h result_hi=%h, required all 0",
                     bus.busy, bus.done, bus.zero, bus.illegal, bus.result, bus.result_hi);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        int lat;
        logic [W-1:0] a, b, r;
        run_op(4'b0010, 5, 7, lat);
        checks++;
        if (lat !== 1 || {bus.result_hi, bus.result, bus.zero, bus.illegal} !== {32'd0, 32'd12, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL add_5_7: lat=%0d result=%0d hi=%0d zero=%b illegal=%b, required lat=1 result=12 hi=0 zero=0 illegal=0",
                     lat, bus.result, bus.result_hi, bus.zero, bus.illegal);
        end
        r = bus.result;
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.result !== r) begin
            failures++;
            $display("FAIL done_pulse: done=%b result=%h, required done=0 result=%h", bus.done, bus.result, r);
        end
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = i == 0 ? -a : $urandom;
            run_op(4'b0010, a, b, lat);
            checks++;
            if (lat !== 1 || {bus.result_hi, bus.result, bus.zero, bus.illegal} !== model(4'b0010, a, b)) begin
                failures++;
                $display("FAIL add_rand: a=%h b=%h lat=%0d got %h_%h z=%b i=%b, required lat=1 %h",
                         a, b, lat, bus.result_hi, bus.result, bus.zero, bus.illegal, model(4'b0010, a, b));
            end
        end
    endtask

    task automatic test_sub();
        int lat;
        logic [W-1:0] a, b;
        run_op(4'b0011, 9, 9, lat);
        checks++;
        if (lat !== 1 || bus.result !== 32'd0 || bus.zero !== 1'b1) begin
            failures++;
            $display("FAIL sub_9_9: lat=%0d result=%h zero=%b, required lat=1 result=0 zero=1", lat, bus.result, bus.zero);
        end
        run_op(4'b0011, 3, 5, lat);
        checks++;
        if (lat !== 1 || bus.result !== 32'hFFFFFFFE || bus.zero !== 1'b0 || bus.result_hi !== 32'd0) begin
            failures++;
            $display("FAIL sub_3_5: lat=%0d result=%h hi=%h zero=%b, required lat=1 result=fffffffe hi=0 zero=0",
                     lat, bus.result, bus.result_hi, bus.zero);
        end
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = i % 3 == 0 ? a : $urandom;
            run_op(4'b0011, a, b, lat);
            checks++;
            if (lat !== 1 || {bus.result_hi, bus.result, bus.zero, bus.illegal} !== model(4'b0011, a, b)) begin
                failures++;
                $display("FAIL sub_rand: a=%h b=%h lat=%0d got %h_%h z=%b i=%b, required lat=1 %h",
                         a, b, lat, bus.result_hi, bus.result, bus.zero, bus.illegal, model(4'b0011, a, b));
            end
        end
    endtask

    task automatic test_mult();
        int lat, bad;
        logic [W-1:0] a, b;
        drive(4'b0100, 32'hFFFFFFFF, 32'hFFFFFFFF);
        tick();
        release_bus();
        bad = 0;
        for (int k = 1; k <= W; k++) begin
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL mult_busy: %0d of %0d cycles not busy or early done, required 0", bad, W);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.result_hi !== 32'hFFFFFFFE || bus.result !== 32'h00000001 || bus.zero !== 1'b0) begin
            failures++;
            $display("FAIL mult_max: done=%b busy=%b product=%h_%h zero=%b, required done=1 busy=0 fffffffe_00000001 zero=0",
                     bus.done, bus.busy, bus.result_hi, bus.result, bus.zero);
        end
        for (int i = 0; i < 6; i++) begin
            a = i == 0 ? 32'd0 : $urandom;
            b = i == 1 ? 32'd0 : $urandom;
            run_op(4'b0100, a, b, lat);
            checks++;
            if (lat !== W + 1 || {bus.result_hi, bus.result, bus.zero, bus.illegal} !== model(4'b0100, a, b)) begin
                failures++;
                $display("FAIL mult_rand: a=%h b=%h lat=%0d got %h_%h z=%b i=%b, required lat=%0d %h",
                         a, b, lat, bus.result_hi, bus.result, bus.zero, bus.illegal, W + 1, model(4'b0100, a, b));
            end
        end
    endtask

    task automatic test_busy_ignore();
        int dones, first;
        logic [W-1:0] a, b;
        a = $urandom;
        b = $urandom;
        drive(4'b0100, a, b);
        tick();
        release_bus();
        dones = 0;
        first = 0;
        for (int k = 1; k <= 45; k++) begin
            if (k == 10) drive(4'b0010, 1, 1);
            if (k == 11) release_bus();
            if (bus.done) begin
                dones++;
                if (first == 0) first = k;
            end
            tick();
        end
        checks++;
        if (dones !== 1 || first !== W + 1) begin
            failures++;
            $display("FAIL busy_ignore_count: dones=%0d first=%0d, required dones=1 first=%0d", dones, first, W + 1);
        end
        checks++;
        if ({bus.result_hi, bus.result, bus.zero, bus.illegal} !== model(4'b0100, a, b)) begin
            failures++;
            $display("FAIL busy_ignore_result: got %h_%h, required %h", bus.result_hi, bus.result, model(4'b0100, a, b));
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        drive(4'b0100, $urandom, $urandom);
        tick();
        release_bus();
        repeat (14) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({bus.busy, bus.done, bus.zero, bus.illegal, bus.result, bus.result_hi} !== '0) begin
            failures++;
            $display("FAIL reset_abort: busy=%b done=%b zero=%b illegal=%b result=%h hi=%h, required all 0",
                     bus.busy, bus.done, bus.zero, bus.illegal, bus.result, bus.result_hi);
        end
        rst_n = 1'b1;
        tick();
        run_op(4'b0010, 1, 1, lat);
        checks++;
        if (lat !== 1 || bus.result !== 32'd2 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL after_reset_add: lat=%0d result=%0d busy=%b, required lat=1 result=2 busy=0", lat, bus.result, bus.busy);
        end
        repeat (40) tick();
        checks++;
        if (bus.result !== 32'd2 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL aborted_mult_leak: result=%h done=%b, required result=2 done=0", bus.result, bus.done);
        end
    endtask

    task automatic test_illegal();
        int lat;
        logic [3:0] c;
        run_op(4'b1111, $urandom, $urandom, lat);
        checks++;
        if (lat !== 1 || bus.illegal !== 1'b1 || bus.result !== '0 || bus.result_hi !== '0 || bus.zero !== 1'b0) begin
            failures++;
            $display("FAIL illegal_1111: lat=%0d illegal=%b result=%h hi=%h zero=%b, required lat=1 illegal=1 0 0 zero=0",
                     lat, bus.illegal, bus.result, bus.result_hi, bus.zero);
        end
        drive(4'b0010, 2, 2);
        tick();
        release_bus();
        checks++;
        if (bus.done !== 1'b1 || bus.result !== 32'd4 || bus.illegal !== 1'b0) begin
            failures++;
            $display("FAIL illegal_then_add: done=%b result=%0d illegal=%b, required done=1 result=4 illegal=0",
                     bus.done, bus.result, bus.illegal);
        end
        for (int i = 0; i < 5; i++) begin
            c = rand_illegal();
            run_op(c, $urandom, $urandom, lat);
            checks++;
            if (lat !== 1 || {bus.result_hi, bus.result, bus.zero, bus.illegal} !== model(c, 0, 0)) begin
                failures++;
                $display("FAIL illegal_rand: code=%b lat=%0d illegal=%b result=%h, required lat=1 illegal=1 result=0",
                         c, lat, bus.illegal, bus.result);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [3:0] c;
        logic [W-1:0] a, b;
        c = rand_ctl();
        a = $urandom;
        b = $urandom;
        drive(c, a, b);
        for (int n = 0; n < 30; n++) begin
            tick();
            release_bus();
            lat = 1;
            while (!bus.done && lat < 40) begin
                tick();
                lat++;
            end
            checks++;
            if (lat !== latency(c) || {bus.result_hi, bus.result, bus.zero, bus.illegal} !== model(c, a, b)) begin
                failures++;
                $display("FAIL back_to_back: n=%0d code=%b a=%h b=%h lat=%0d got %h_%h z=%b i=%b, required lat=%0d %h",
                         n, c, a, b, lat, bus.result_hi, bus.result, bus.zero, bus.illegal, latency(c), model(c, a, b));
            end
            c = rand_ctl();
            a = $urandom;
            b = $urandom;
            if (n < 29) drive(c, a, b);
        end
        tick();
    endtask

    initial begin
        release_bus();
        test_reset();
        test_add();
        test_sub();
        test_mult();
        test_busy_ignore();
        test_reset_abort();
        test_illegal();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
